// File: rtl/random_gen.sv
// Sequential random-number unit built around a combinational 8-bit LFSR step.
// A request advances the LFSR STEPS times. The result is then presented on a
// valid/ack handshake. Software can reseed the generator while it is idle.

// One Galois-free Fibonacci step: shift left, feedback from taps 7,5,4,3.
module random (
    input  logic [7:0] i_lfsr,
    output logic [7:0] o_next
);
    assign o_next = {i_lfsr[6:0], i_lfsr[7] ^ i_lfsr[5] ^ i_lfsr[4] ^ i_lfsr[3]};
endmodule

module random_gen #(
    parameter int          STEPS        = 8,
    parameter logic [7:0]  DEFAULT_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_we,
    input  logic [7:0] seed_in,
    input  logic       req,
    input  logic       ack,
    output logic       busy,
    output logic       valid,
    output logic [7:0] rnd
);
    localparam logic [7:0] STEPS_W = 8'(STEPS);

    // A zero step count would never produce a result, and a zero seed would
    // lock the LFSR, so both are rejected at elaboration.
    generate
        if (STEPS < 1 || STEPS > 255) begin : g_bad_steps
            $error("random_gen: STEPS must be in 1..255");
        end
        if (DEFAULT_SEED == 8'h00) begin : g_bad_seed
            $error("random_gen: DEFAULT_SEED must be nonzero");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_lfsr;
    logic [7:0] r_cnt;
    logic [7:0] r_rnd;
    logic       r_valid;
    logic [7:0] w_lfsr_next;
    logic       w_start;

    random u_step (
        .i_lfsr (r_lfsr),
        .o_next (w_lfsr_next)
    );

    // A seed write in the same cycle wins and the request is dropped.
    assign w_start = req && !seed_we;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode. RUN leaves once the step counter has drained.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start)        w_state_next = S_RUN;
            S_RUN:  if (r_cnt == 8'd0)  w_state_next = S_DONE;
            S_DONE: if (ack)            w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // Datapath: seeding, stepping and result capture. The count is
    // loaded with STEPS on the request edge. Each RUN edge with a
    // nonzero count advances the LFSR once. The edge that sees the
    // count at zero publishes the result, which places valid STEPS+1
    // edges after the request was sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= DEFAULT_SEED;
            r_cnt   <= 8'd0;
            r_rnd   <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (seed_we) begin
                        r_lfsr <= (seed_in == 8'h00) ? DEFAULT_SEED : seed_in;
                    end else if (req) begin
                        r_cnt <= STEPS_W;
                    end
                end
                S_RUN: begin
                    if (r_cnt != 8'd0) begin
                        r_lfsr <= w_lfsr_next;
                        r_cnt  <= r_cnt - 8'd1;
                    end else begin
                        r_rnd   <= r_lfsr;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign valid = r_valid;
    assign rnd   = r_rnd;

endmodule

// File: tb/tb_random_gen.sv
// Directed bench for random_gen: one instance with STEPS=1, one with STEPS=8.
// Expected results come from a reference LFSR model and are queued per instance
// when a request is issued, then popped when valid rises.
`timescale 1ns/1ps
module tb_random_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       seed_we1 = 1'b0, req1 = 1'b0, ack1 = 1'b0;
    logic [7:0] seed_in1 = 8'h00;
    logic       busy1, valid1;
    logic [7:0] rnd1;

    logic       seed_we8 = 1'b0, req8 = 1'b0, ack8 = 1'b0;
    logic [7:0] seed_in8 = 8'h00;
    logic       busy8, valid8;
    logic [7:0] rnd8;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m1, m8;
    logic [7:0] q1[$];
    logic [7:0] q8[$];

    always #5 clk = ~clk;

    random_gen #(.STEPS(1), .DEFAULT_SEED(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .seed_we(seed_we1), .seed_in(seed_in1),
        .req(req1), .ack(ack1), .busy(busy1), .valid(valid1), .rnd(rnd1)
    );

    random_gen #(.STEPS(8), .DEFAULT_SEED(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .seed_we(seed_we8), .seed_in(seed_in8),
        .req(req8), .ack(ack8), .busy(busy8), .valid(valid8), .rnd(rnd8)
    );

    function automatic logic [7:0] ref_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle request and queue the model's expected result.
    task automatic do_req(input int sel);
        if (sel == 1) begin
            req1 = 1'b1; tick(); req1 = 1'b0;
            m1 = ref_step(m1);
            q1.push_back(m1);
            check("req1_busy", busy1, 1);
            $display("T=%0t dut1 req issued, expect rnd=%02h", $time, m1);
        end else begin
            req8 = 1'b1; tick(); req8 = 1'b0;
            for (int i = 0; i < 8; i++) m8 = ref_step(m8);
            q8.push_back(m8);
            check("req8_busy", busy8, 1);
            $display("T=%0t dut8 req issued, expect rnd=%02h", $time, m8);
        end
    endtask

    // Wait (bounded) for valid, then check latency and the scoreboard entry.
    task automatic wait_done(input int sel, input int n0);
        int n;
        logic [7:0] exp;
        n = n0;
        if (sel == 1) begin
            while (!valid1 && n < 300) begin tick(); n++; end
            check("lat1", n, 2);
            check("sb1_pending", q1.size(), 1);
            if (q1.size() > 0) begin
                exp = q1.pop_front();
                check("rnd1", rnd1, exp);
            end
            $display("T=%0t dut1 result rnd=%02h after %0d edges", $time, rnd1, n);
        end else begin
            while (!valid8 && n < 300) begin tick(); n++; end
            check("lat8", n, 9);
            check("sb8_pending", q8.size(), 1);
            if (q8.size() > 0) begin
                exp = q8.pop_front();
                check("rnd8", rnd8, exp);
            end
            $display("T=%0t dut8 result rnd=%02h after %0d edges", $time, rnd8, n);
        end
    endtask

    task automatic do_ack(input int sel);
        if (sel == 1) begin
            ack1 = 1'b1; tick(); ack1 = 1'b0;
            check("ack1_valid", valid1, 0);
            check("ack1_busy", busy1, 0);
            $display("T=%0t dut1 ack", $time);
        end else begin
            ack8 = 1'b1; tick(); ack8 = 1'b0;
            check("ack8_valid", valid8, 0);
            check("ack8_busy", busy8, 0);
            $display("T=%0t dut8 ack", $time);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        m1 = 8'hA5; m8 = 8'hA5;
        check("rst_busy1", busy1, 0);
        check("rst_valid1", valid1, 0);
        check("rst_rnd1", rnd1, 8'h00);
        check("rst_busy8", busy8, 0);
        check("rst_valid8", valid8, 0);
        check("rst_rnd8", rnd8, 8'h00);

        // STEPS=1 from the default seed
        do_req(1);
        wait_done(1, 0);
        check("t1_const", rnd1, 8'h4A);
        do_ack(1);
        check("t1_rnd_kept", rnd1, 8'h4A);

        // STEPS=8 from seed 0x80; req/seed_we while busy are ignored
        seed_in8 = 8'h80; seed_we8 = 1'b1; tick(); seed_we8 = 1'b0;
        m8 = 8'h80;
        do_req(8);
        req8 = 1'b1; seed_we8 = 1'b1; seed_in8 = 8'h55;
        tick(); tick();
        req8 = 1'b0; seed_we8 = 1'b0;
        wait_done(8, 2);
        check("t2_const", rnd8, 8'h8E);
        // Hold in DONE with ack low; stray req/seed_we must not disturb anything
        req8 = 1'b1; seed_we8 = 1'b1; seed_in8 = 8'h33;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid8", valid8, 1);
            check("hold_rnd8", rnd8, 8'h8E);
        end
        do_ack(8);
        req8 = 1'b0; seed_we8 = 1'b0;
        check("t2_rnd_kept", rnd8, 8'h8E);
        tick();
        check("ackcyc_req_dropped", busy8, 0);
        // Sequence continues from the frozen state, unaffected by ignored seeds
        do_req(8);
        wait_done(8, 0);
        do_ack(8);

        // Zero seed is replaced by the default seed
        seed_in1 = 8'h00; seed_we1 = 1'b1; tick(); seed_we1 = 1'b0;
        m1 = 8'hA5;
        do_req(1);
        wait_done(1, 0);
        check("t3_const", rnd1, 8'h4A);
        do_ack(1);

        // seed_we and req together: seed wins, request is dropped
        seed_in1 = 8'hB8; seed_we1 = 1'b1; req1 = 1'b1; tick();
        seed_we1 = 1'b0; req1 = 1'b0;
        m1 = 8'hB8;
        for (int i = 0; i < 3; i++) begin
            check("t4_busy1", busy1, 0);
            check("t4_valid1", valid1, 0);
            tick();
        end

        // Two back-to-back rounds from seed 0xB8
        do_req(1);
        wait_done(1, 0);
        check("t6_const", rnd1, 8'h70);
        do_ack(1);
        do_req(1);
        wait_done(1, 0);
        do_ack(1);

        // Reset in the middle of a STEPS=8 run discards the request
        do_req(8);
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        q8.delete();
        m8 = 8'hA5; m1 = 8'hA5;
        check("t5_busy8", busy8, 0);
        check("t5_valid8", valid8, 0);
        check("t5_rnd8", rnd8, 8'h00);
        check("t5_rnd1", rnd1, 8'h00);
        tick();
        check("t5_stays_idle", busy8, 0);
        do_req(1);
        wait_done(1, 0);
        check("t5_const", rnd1, 8'h4A);
        do_ack(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
